// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, debounces the
// first low row it finds, and reports that key until it is released.
module keypad_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 8
) (
  input  logic       clock50MHz,
  input  logic       reset,
  input  logic [3:0] Rows,
  output logic [3:0] Cols,
  output logic [3:0] KeyCode,
  output logic       KeyValid,
  output logic       KeyHeld
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [TW-1:0] DIV_LAST = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE - 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  // Lowest-index low row wins when several rows share the driven column.
  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    logic [1:0] idx;
    casez (r)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  logic [3:0]    sync1_r, rs_r;
  logic [TW-1:0] div_r;
  logic [1:0]    state_r, col_r, cand_row_r, cand_col_r;
  logic [DW-1:0] dcnt_r, rcnt_r;
  logic [3:0]    cols_r, code_r;
  logic          valid_r, held_r;

  logic          tick_s, cand_low_s;
  logic [1:0]    state_s, col_s, cand_row_s, cand_col_s;
  logic [DW-1:0] dcnt_s, rcnt_s;
  logic [3:0]    code_s;
  logic          valid_s, held_s;

  assign tick_s     = (div_r == DIV_LAST);
  assign cand_low_s = ~rs_r[cand_row_r];

  // Row synchronizer and scan-tick divider.
  always_ff @(posedge clock50MHz or negedge reset) begin
    if (!reset) begin
      sync1_r <= 4'b1111;
      rs_r    <= 4'b1111;
      div_r   <= '0;
    end else begin
      sync1_r <= Rows;
      rs_r    <= sync1_r;
      div_r   <= tick_s ? '0 : div_r + TW'(1);
    end
  end

  // Scan / debounce / held next-state logic; everything advances only on a tick.
  always_comb begin
    state_s    = state_r;
    col_s      = col_r;
    cand_row_s = cand_row_r;
    cand_col_s = cand_col_r;
    dcnt_s     = dcnt_r;
    rcnt_s     = rcnt_r;
    code_s     = code_r;
    valid_s    = 1'b0;
    held_s     = held_r;
    if (tick_s) begin
      case (state_r)
        ST_SCAN: begin
          if (rs_r != 4'b1111) begin
            cand_row_s = lowest_low(rs_r);
            cand_col_s = col_r;
            dcnt_s     = DW'(1);
            state_s    = ST_DEBOUNCE;
          end else begin
            col_s = col_r + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (!cand_low_s) begin
            col_s   = col_r + 2'd1;
            state_s = ST_SCAN;
          end else if (dcnt_r >= DB_LAST) begin
            dcnt_s  = DB_MAX;
            rcnt_s  = '0;
            code_s  = {cand_row_s, cand_col_s};
            valid_s = 1'b1;
            held_s  = 1'b1;
            state_s = ST_HELD;
          end else begin
            dcnt_s = dcnt_r + DW'(1);
          end
        end
        ST_HELD: begin
          if (cand_low_s) begin
            rcnt_s = '0;
          end else if (rcnt_r >= DB_LAST) begin
            rcnt_s  = DB_MAX;
            held_s  = 1'b0;
            col_s   = col_r + 2'd1;
            state_s = ST_SCAN;
          end else begin
            rcnt_s = rcnt_r + DW'(1);
          end
        end
        default: begin
          held_s  = 1'b0;
          state_s = ST_SCAN;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Scanner state and registered outputs.
  always_ff @(posedge clock50MHz or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_SCAN;
      col_r      <= 2'd0;
      cand_row_r <= 2'd0;
      cand_col_r <= 2'd0;
      dcnt_r     <= '0;
      rcnt_r     <= '0;
      cols_r     <= 4'b1110;
      code_r     <= 4'd0;
      valid_r    <= 1'b0;
      held_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      col_r      <= col_s;
      cand_row_r <= cand_row_s;
      cand_col_r <= cand_col_s;
      dcnt_r     <= dcnt_s;
      rcnt_r     <= rcnt_s;
      cols_r     <= ~(4'b0001 << col_s);
      code_r     <= code_s;
      valid_r    <= valid_s;
      held_r     <= held_s;
    end
  end

  assign Cols     = cols_r;
  assign KeyCode  = code_r;
  assign KeyValid = valid_r;
  assign KeyHeld  = held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed corner sequences, a table of keypad
// presses, and random keypad/row traffic checked every clock against a model.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows, cols, key_code;
  logic       key_valid, key_held;

  logic       use_pad;
  logic [3:0] rows_drv;
  logic [15:0] pad;
  logic [3:0] pad_rows;

  int checks = 0;
  int errors = 0;
  int dut_pulses = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clock50MHz(clk),
    .reset(reset),
    .Rows(rows),
    .Cols(cols),
    .KeyCode(key_code),
    .KeyValid(key_valid),
    .KeyHeld(key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    pad_rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pad[r*4+c] && (cols[c] === 1'b0)) pad_rows[r] = 1'b0;
  end
  assign rows = use_pad ? pad_rows : rows_drv;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the scanner described in terms of ticks, a pipe of
  // sampled rows and an agreement counter.
  int m_s1, m_s2, m_div, m_col, m_mode, m_cand_r, m_cand_c, m_cnt, m_code;
  int m_valid, m_held;
  bit prev_valid = 1'b0;

  task automatic model_step(input logic rst, input logic [3:0] r_in);
    int rs;
    bit tick;
    if (!rst) begin
      m_s1 = 15; m_s2 = 15; m_div = 0; m_col = 0; m_mode = 0; m_cnt = 0;
      m_code = 0; m_valid = 0; m_held = 0; m_cand_r = 0; m_cand_c = 0;
      return;
    end
    rs = m_s2;
    m_s2 = m_s1;
    m_s1 = int'(r_in);
    tick = (m_div == SD - 1);
    m_div = (m_div + 1) % SD;
    m_valid = 0;
    if (!tick) return;
    if (m_mode == 0) begin
      if (rs != 15) begin
        for (int i = 3; i >= 0; i--) if (((rs >> i) & 1) == 0) m_cand_r = i;
        m_cand_c = m_col;
        m_cnt = 1;
        m_mode = 1;
      end else m_col = (m_col + 1) % 4;
    end else if (m_mode == 1) begin
      if (((rs >> m_cand_r) & 1) == 0) begin
        m_cnt++;
        if (m_cnt >= DB) begin
          m_code = m_cand_r * 4 + m_cand_c;
          m_valid = 1; m_held = 1; m_mode = 2; m_cnt = 0;
        end
      end else begin
        m_col = (m_col + 1) % 4;
        m_mode = 0;
      end
    end else begin
      if (((rs >> m_cand_r) & 1) == 1) m_cnt++;
      else m_cnt = 0;
      if (m_cnt >= DB) begin
        m_held = 0; m_col = (m_col + 1) % 4; m_mode = 0;
      end
    end
  endtask

  // Per-clock scoreboard, sampled 1 time unit after the rising edge.
  initial begin
    logic [3:0] r_now, exp_cols;
    logic rst_now;
    forever begin
      @(posedge clk);
      r_now = rows;
      rst_now = reset;
      model_step(rst_now, r_now);
      #1;
      exp_cols = ~(4'b0001 << m_col);
      check("cols_model", cols, exp_cols);
      check("code_model", key_code, 4'(m_code));
      check("valid_model", {3'b000, key_valid}, 4'(m_valid));
      check("held_model", {3'b000, key_held}, 4'(m_held));
      if (key_valid === 1'b1) begin
        dut_pulses++;
        check("valid_not_back_to_back", {3'b000, prev_valid}, 4'd0);
      end
      prev_valid = (key_valid === 1'b1);
    end
  end

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge on which reset is released (scan time zero).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; use_pad = 1'b0; pad = 16'h0000; rows_drv = 4'b1111;
    clocks(3);
    reset = 1'b1;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_cols"}, cols, 4'b1110);
    check({nm, "_code"}, key_code, 4'h0);
    check({nm, "_valid"}, {3'b000, key_valid}, 4'd0);
    check({nm, "_held"}, {3'b000, key_held}, 4'd0);
  endtask

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  exp_code;
    logic [3:0]  exp_cols;
  } vec_t;

  vec_t vecs[6];
  logic [3:0] rot[4];

  initial begin
    int p0;
    reset = 1'b0; use_pad = 1'b0; pad = 16'h0000; rows_drv = 4'b1111;

    vecs[0] = '{16'h0001, 4'b0000, 4'b1110};
    vecs[1] = '{16'h8000, 4'b1111, 4'b0111};
    vecs[2] = '{16'h0200, 4'b1001, 4'b1101};
    vecs[3] = '{16'h0040, 4'b0110, 4'b1011};
    vecs[4] = '{16'h8080, 4'b0111, 4'b0111};
    vecs[5] = '{16'h0140, 4'b1000, 4'b1110};
    rot[0] = 4'b1101; rot[1] = 4'b1011; rot[2] = 4'b0111; rot[3] = 4'b1110;

    // Reset held with rows toggling, then column rotation.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rows_drv = 4'(i * 5);
      check_reset_outputs("in_reset");
    end
    rows_drv = 4'b1111;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clocks(SD);
      check("rotate", cols, rot[i]);
    end

    // Row 2 on column 1, then a bouncy release.
    do_reset();
    clocks(4);
    check("press_col1", cols, 4'b1101);
    p0 = dut_pulses;
    rows_drv = 4'b1011;
    clocks(11);
    check("no_early_pulse", 4'(dut_pulses - p0), 4'd0);
    check("not_held_early", {3'b000, key_held}, 4'd0);
    clocks(1);
    check("strobe_3rd_tick", {3'b000, key_valid}, 4'd1);
    check("code_1001", key_code, 4'b1001);
    check("held_after", {3'b000, key_held}, 4'd1);
    rows_drv = 4'b1111;
    clocks(1);
    check("strobe_one_clock", {3'b000, key_valid}, 4'd0);
    check("cols_frozen", cols, 4'b1101);
    clocks(7);
    rows_drv = 4'b1011;
    clocks(4);
    rows_drv = 4'b1111;
    clocks(8);
    check("held_through_bounce", {3'b000, key_held}, 4'd1);
    clocks(4);
    check("released", {3'b000, key_held}, 4'd0);
    check("scan_resumes", cols, 4'b1011);
    check("single_pulse", 4'(dut_pulses - p0), 4'd1);
    check("code_kept", key_code, 4'b1001);

    // Press bounce: two good ticks then high.
    do_reset();
    p0 = dut_pulses;
    rows_drv = 4'b1110;
    clocks(4);
    check("deb_col_hold", cols, 4'b1110);
    clocks(4);
    rows_drv = 4'b1111;
    clocks(4);
    check("bounce_next_col", cols, 4'b1101);
    check("bounce_no_held", {3'b000, key_held}, 4'd0);
    check("bounce_no_pulse", 4'(dut_pulses - p0), 4'd0);

    // Two rows low on column 2: row 0 wins.
    do_reset();
    clocks(8);
    check("at_col2", cols, 4'b1011);
    p0 = dut_pulses;
    rows_drv = 4'b0110;
    clocks(12);
    check("prio_strobe", {3'b000, key_valid}, 4'd1);
    check("prio_code", key_code, 4'b0010);
    clocks(8);
    check("prio_one_pulse", 4'(dut_pulses - p0), 4'd1);
    rows_drv = 4'b1111;

    // Reset during debounce aborts the press.
    do_reset();
    p0 = dut_pulses;
    rows_drv = 4'b1110;
    clocks(10);
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    clocks(10);
    check_reset_outputs("abort_hold");
    check("abort_no_pulse", 4'(dut_pulses - p0), 4'd0);
    rows_drv = 4'b1111;
    reset = 1'b1;

    // Keypad table.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      use_pad = 1'b1;
      pad = vecs[v].keys;
      p0 = dut_pulses;
      clocks(48);
      check("tbl_pulses", 4'(dut_pulses - p0), 4'd1);
      check("tbl_code", key_code, vecs[v].exp_code);
      check("tbl_held", {3'b000, key_held}, 4'd1);
      check("tbl_cols", cols, vecs[v].exp_cols);
      pad = 16'h0000;
      clocks(24);
      check("tbl_release", {3'b000, key_held}, 4'd0);
      check("tbl_code_kept", key_code, vecs[v].exp_code);
    end

    // Random keypad presses, row noise and occasional resets.
    do_reset();
    for (int e = 0; e < 200; e++) begin
      int kind;
      kind = int'($urandom_range(0, 4));
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b0;
        clocks(2);
        reset = 1'b1;
      end
      if (kind < 3) begin
        use_pad = 1'b1;
        pad = 16'h0000;
        if (kind > 0) pad[$urandom_range(0, 15)] = 1'b1;
        if (kind > 1) pad[$urandom_range(0, 15)] = 1'b1;
        clocks(int'($urandom_range(1, 40)));
      end else begin
        use_pad = 1'b0;
        rows_drv = 4'($urandom);
        clocks(int'($urandom_range(1, 6)));
      end
    end
    use_pad = 1'b0;
    rows_drv = 4'b1111;
    clocks(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
